// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Cache-to-memory bus bundle shared by the I-cache, D-cache,
//            memory model and mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              icache_mem_read;
    logic [ADDR_W-1:0] icache_mem_addr;
    logic [DATA_W-1:0] icache_mem_rdata;
    logic              icache_mem_ready;

    logic              dcache_mem_read;
    logic              dcache_mem_write;
    logic [ADDR_W-1:0] dcache_mem_addr;
    logic [DATA_W-1:0] dcache_mem_wdata;
    logic [DATA_W-1:0] dcache_mem_rdata;
    logic              dcache_mem_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    // Environment side: both caches plus the memory model.
    modport master (
        output icache_mem_read, icache_mem_addr,
        output dcache_mem_read, dcache_mem_write, dcache_mem_addr, dcache_mem_wdata,
        output mem_rdata, mem_ready,
        input  icache_mem_rdata, icache_mem_ready,
        input  dcache_mem_rdata, dcache_mem_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  icache_mem_read, icache_mem_addr,
        input  dcache_mem_read, dcache_mem_write, dcache_mem_addr, dcache_mem_wdata,
        input  mem_rdata, mem_ready,
        output icache_mem_rdata, icache_mem_ready,
        output dcache_mem_rdata, dcache_mem_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one memory port between I-cache and
//            D-cache. Optional macro ARB_WB_LOCK_EN keeps a D-cache write-back
//            and its following refill back-to-back.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W         = 28,
    parameter int DATA_W         = 128,
    parameter int RELEASE_CYCLES = 1
) (
    input  wire logic     clk,
    input  wire logic     proc_reset,
    mem_arbiter_if.slave  bus
);
    localparam int c_CNT_W = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    generate
        if (RELEASE_CYCLES < 1) begin : g_bad_release
            $error("mem_arbiter: RELEASE_CYCLES must be at least 1");
        end
    endgenerate

    logic [1:0]         r_state;
    logic               r_grant;
    logic               r_last_grant;
`ifdef ARB_WB_LOCK_EN
    logic               r_last_was_dwrite;
`endif
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;

    logic               w_i_req;
    logic               w_d_req;
    logic               w_pick_d;
    logic               w_busy;

    assign w_i_req = bus.icache_mem_read;
    assign w_d_req = bus.dcache_mem_read | bus.dcache_mem_write;
    assign w_busy  = (r_state == S_BUSY);

    always_comb begin
        w_pick_d = w_d_req;
        if (w_i_req && w_d_req) begin
`ifdef ARB_WB_LOCK_EN
            w_pick_d = r_last_was_dwrite | ~r_last_grant;
`else
            w_pick_d = ~r_last_grant;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
`ifdef ARB_WB_LOCK_EN
            r_last_was_dwrite <= 1'b0;
`endif
            r_cnt        <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_i_req || w_d_req) begin
                        r_grant <= w_pick_d;
                        r_state <= S_BUSY;
`ifdef ARB_WB_LOCK_EN
                        r_last_was_dwrite <= 1'b0;
`endif
                        if (w_pick_d) begin
                            // A D-cache asserting read and write together is a write.
                            r_mem_addr  <= bus.dcache_mem_addr;
                            r_mem_write <= bus.dcache_mem_write;
                            r_mem_read  <= ~bus.dcache_mem_write;
                            if (bus.dcache_mem_write) begin
                                r_mem_wdata <= bus.dcache_mem_wdata;
                            end
                        end else begin
                            r_mem_addr  <= bus.icache_mem_addr;
                            r_mem_read  <= 1'b1;
                            r_mem_write <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ready) begin
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_last_grant <= r_grant;
`ifdef ARB_WB_LOCK_EN
                        r_last_was_dwrite <= r_grant & r_mem_write;
`endif
                        r_cnt        <= c_CNT_W'(RELEASE_CYCLES);
                        r_state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Dead time lets the served cache drop its registered request.
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.icache_mem_ready = bus.mem_ready & w_busy & ~r_grant;
    assign bus.dcache_mem_ready = bus.mem_ready & w_busy &  r_grant;
    assign bus.icache_mem_rdata = bus.mem_rdata;
    assign bus.dcache_mem_rdata = bus.mem_rdata;

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 128-bit main-memory port between the instruction cache (read-only) and the data cache (read/write-back). It sits between both cache instances and the memory model in the RISC-V top level. It registers each winning request onto the memory bus, routes `mem_ready` back only to the granted cache, and inserts a release gap so a cache's registered-ready cycle cannot start a duplicate transaction.

## Interface
Parameters:
- `ADDR_W`, 28, block address width
- `DATA_W`, 128, block data width
- `RELEASE_CYCLES`, 1, dead cycles after each completion (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `proc_reset`  in  1  synchronous, active-high reset
- `icache_mem_read`  in  1  I-cache read request (level, held until served)
- `icache_mem_addr`  in  ADDR_W  I-cache block address
- `icache_mem_rdata`  out  DATA_W  read data to I-cache
- `icache_mem_ready`  out  1  completion pulse to I-cache
- `dcache_mem_read`  in  1  D-cache read request
- `dcache_mem_write`  in  1  D-cache write-back request
- `dcache_mem_addr`  in  ADDR_W  D-cache block address
- `dcache_mem_wdata`  in  DATA_W  D-cache write-back data
- `dcache_mem_rdata`  out  DATA_W  read data to D-cache
- `dcache_mem_ready`  out  1  completion pulse to D-cache
- `mem_read`  out  1  memory read strobe (registered)
- `mem_write`  out  1  memory write strobe (registered)
- `mem_addr`  out  ADDR_W  memory address (registered)
- `mem_wdata`  out  DATA_W  memory write data (registered)
- `mem_rdata`  in  DATA_W  memory read data
- `mem_ready`  in  1  memory completion pulse

## Operation
- States: `S_IDLE`, `S_BUSY`, `S_RELEASE`. Registers: `grant` (0=I, 1=D), `last_grant`, `last_was_dwrite`, release counter, mem output registers.
- Requests: `i_req = icache_mem_read`; `d_req = dcache_mem_read | dcache_mem_write`. If D-cache asserts both, write wins.
- `S_IDLE`: no request → stay. Exactly one request → grant it. Both → round-robin: grant the requester that is not `last_grant`. On grant: latch requester's addr/wdata and read/write type into mem registers; go `S_BUSY`.
- `S_BUSY`: mem registers held constant; requester inputs ignored. On `mem_ready`: pulse the granted cache's ready the same cycle, clear `mem_read`/`mem_write` at the edge, update `last_grant` and `last_was_dwrite`, load counter with `RELEASE_CYCLES`, go `S_RELEASE`.
- `S_RELEASE`: all requests ignored; decrement counter; at 1 → `S_IDLE`.
- Ready routing: `icache_mem_ready = mem_ready & S_BUSY & grant==0`; `dcache_mem_ready = mem_ready & S_BUSY & grant==1`. `mem_ready` outside `S_BUSY` is ignored.
- `icache_mem_rdata` and `dcache_mem_rdata` are both wired directly to `mem_rdata`; validity is qualified by the ready pulses.
- `mem_addr`/`mem_wdata` keep their last values when idle. Read transactions do not update `mem_wdata`.

## Timing
- Reset: state `S_IDLE`, `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`, `last_grant=1` (I-cache wins the first tie), `last_was_dwrite=0`. Both ready outputs are 0.
- Reset asserted mid-transaction aborts it. Strobes are low after the next edge, and no ready pulse follows.
- Request sampled in `S_IDLE` at cycle t → strobe high at t+1.
- `mem_ready` at cycle k → cache ready at k, strobe low from k+1, `S_RELEASE` during k+1..k+RELEASE_CYCLES, `S_IDLE` at k+RELEASE_CYCLES+1. The earliest next strobe is at k+RELEASE_CYCLES+2.
- Minimum transaction spacing holds regardless of which requester is waiting.

## Configuration
- `ARB_WB_LOCK_EN` defined: after a completed D-cache write, the next `S_IDLE` arbitration grants the D-cache if `d_req` is high, regardless of round-robin. This keeps write-back and refill back-to-back. If `d_req` is low, normal arbitration applies. `last_was_dwrite` clears on any grant.
- Not defined: `last_was_dwrite` is unused and the next grant follows plain round-robin.

## Test plan
- I-cache only: `icache_mem_read=1`, addr `28'h0000123`, memory ready 3 cycles after strobe, `mem_rdata=128'hA5…` → `mem_read=1` with `mem_addr=28'h0000123`. `icache_mem_ready` pulses once with data `128'hA5…`. `dcache_mem_ready` stays 0.
- Simultaneous I and D reads after reset → I-cache served first. The D-cache strobe appears exactly RELEASE_CYCLES+2 cycles after the I-cache `mem_ready`.
- D-cache write-back (addr `28'h0000040`, wdata `128'h1234…`), then read of `28'h0000080`, with I-cache requesting throughout:
  - With `ARB_WB_LOCK_EN`: order is D-write, D-read, I-read.
  - Without `ARB_WB_LOCK_EN`: order is D-write, I-read, D-read.
- Served requester holds its request through the release cycle → no second `mem_read`/`mem_write` pulse is issued.
- Requester changes `dcache_mem_addr` during `S_BUSY` → `mem_addr` is unchanged until completion.
- `proc_reset` pulsed during `S_BUSY` → strobes are 0 at the next edge and no ready pulse follows. A new request after reset is served normally.
